pid_pwm: RTL and testbench

PID_PWM -- requirements
Module: pid_pwm

---
 rtl/flight_pkg.sv | 12 +
 rtl/pwm_counter.sv | 46 ++++
 rtl/pid_pwm.sv | 142 ++++++++++++++
 tb/tb_pid_pwm.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flight_pkg.sv
// Shared definitions for the flight motor-drive blocks.
package flight_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int SHIFT_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_counter.sv
// PWM period counter: counts 0..period_q-1, flags the wrap cycle and
// re-samples the period only at wrap (and once right after reset).
module pwm_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_period_q,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_q;
  logic             r_loaded;
  logic             w_run;

  // Periods below 2 park the counter at 0 and never wrap.
  assign w_run  = (r_period_q >= CNT_W'(2));
  assign o_wrap = i_en && r_loaded && w_run && (r_cnt == r_period_q - CNT_W'(1));

  // Counter and period register; everything freezes while disabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt      <= '0;
      r_period_q <= '0;
      r_loaded   <= 1'b0;
    end else if (i_en) begin
      if (!r_loaded) begin
        r_period_q <= i_period;
        r_loaded   <= 1'b1;
      end else if (o_wrap) begin
        r_cnt      <= '0;
        r_period_q <= i_period;
      end else if (w_run) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt      = r_cnt;
  assign o_period_q = r_period_q;

endmodule

// File: rtl/pid_pwm.sv
// PID-to-PWM motor driver: scales and clamps the PID output, double-buffers
// it through a pending register, and applies it only at PWM period wrap.
module pid_pwm
  import flight_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [31:0]      pid_out,
  input  logic             pid_done,
  input  logic [CNT_W-1:0] base_duty,
  input  logic [CNT_W-1:0] min_duty,
  input  logic [CNT_W-1:0] max_duty,
  input  logic [CNT_W-1:0] period,
  output logic             pwm,
  output logic [CNT_W-1:0] duty_active,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             overrun
);

  // Counter
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_period_q;
  logic             w_wrap;

  pwm_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .nrst       (nrst),
    .i_en       (en),
    .i_period   (period),
    .o_cnt      (w_cnt),
    .o_period_q (w_period_q),
    .o_wrap     (w_wrap)
  );

  // Target: 33-bit signed so base + scaled PID can never wrap.
  logic signed [31:0] w_pid_sh;
  logic signed [32:0] w_target;
  logic signed [32:0] w_min33;
  logic signed [32:0] w_max33;
  logic [CNT_W-1:0]   w_clamped;
  logic               w_hi;
  logic               w_lo;

  assign w_pid_sh = $signed(pid_out) >>> SHIFT;
  assign w_target = $signed({{(33-CNT_W){1'b0}}, base_duty}) + $signed({w_pid_sh[31], w_pid_sh});
  assign w_min33  = $signed({{(33-CNT_W){1'b0}}, min_duty});
  assign w_max33  = $signed({{(33-CNT_W){1'b0}}, max_duty});

  // Clamp target into [min_duty, max_duty] and flag which side saturated.
  always_comb begin
    w_clamped = w_target[CNT_W-1:0];
    w_hi      = 1'b0;
    w_lo      = 1'b0;
    if (w_target < w_min33) begin
      w_clamped = min_duty;
      w_lo      = 1'b1;
    end else if (w_target > w_max33) begin
      w_clamped = max_duty;
      w_hi      = 1'b1;
    end
  end

  // Pending buffer and applied duty
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic [CNT_W-1:0] r_duty;
  logic             r_sat_hi;
  logic             r_sat_lo;
  logic             r_overrun;
  logic             w_sample;
  logic             w_load;

  assign w_sample = pid_done && en;
  assign w_load   = w_wrap && r_pend_vld;

  // Sample capture, wrap transfer and overrun detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_duty     <= '0;
      r_sat_hi   <= 1'b0;
      r_sat_lo   <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (en) begin
      if (w_load)
        r_duty <= r_pend;
      if (w_sample) begin
        r_pend     <= w_clamped;
        r_pend_vld <= 1'b1;
        r_sat_hi   <= w_hi;
        r_sat_lo   <= w_lo;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
      // A sample landing on wrap is a hand-off, not a loss.
      r_overrun <= w_sample && r_pend_vld && !w_wrap;
    end else begin
      r_overrun <= 1'b0;
    end
  end

  // FSM
  pwm_state_e r_state;
  pwm_state_e w_state_nxt;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Leave IDLE on the first duty load; RUN is sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_load) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered PWM compare; one cycle behind the counter.
  logic r_pwm;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_pwm <= 1'b0;
    else       r_pwm <= (r_state == ST_RUN) && en && (w_period_q >= CNT_W'(2)) &&
                        (w_cnt < r_duty);
  end

  assign pwm         = r_pwm;
  assign duty_active = r_duty;
  assign sat_hi      = r_sat_hi;
  assign sat_lo      = r_sat_lo;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_pid_pwm.sv
// Directed bench for pid_pwm; a small counter model tracks where in the
// period the DUT is so strobes can be placed on exact cycles.
module tb_pid_pwm;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [31:0] pid_out;
  logic        pid_done;
  logic [15:0] base_duty, min_duty, max_duty, period;
  logic        pwm;
  logic [15:0] duty_active;
  logic        sat_hi, sat_lo, overrun;

  int checks = 0;
  int fails  = 0;

  int m_cnt = 0;
  int m_perq = 0;
  bit m_first = 1'b1;

  pid_pwm dut (
    .clk(clk), .nrst(nrst), .en(en), .pid_out(pid_out), .pid_done(pid_done),
    .base_duty(base_duty), .min_duty(min_duty), .max_duty(max_duty), .period(period),
    .pwm(pwm), .duty_active(duty_active), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (en) begin
      if (m_first) begin
        m_perq  = int'(period);
        m_first = 1'b0;
      end else if (m_perq >= 2) begin
        if (m_cnt == m_perq - 1) begin
          m_cnt  = 0;
          m_perq = int'(period);
        end else m_cnt++;
      end
    end
    #1;
  endtask

  task automatic go_to_cnt(input int v);
    int n;
    n = 0;
    do begin tick(); n++; end while (m_cnt != v && n < 400);
  endtask

  task automatic pulse(input logic [31:0] v);
    pid_out  = v;
    pid_done = 1'b1;
    tick();
    pid_done = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
    m_first = 1'b1; m_cnt = 0; m_perq = 0;
  endtask

  // Run n cycles checking pwm against the duty, then the total high count.
  task automatic run_period(input int n, input int duty, input int exp_hi, input string nm);
    int prev, errs, highs;
    errs = 0; highs = 0;
    for (int i = 0; i < n; i++) begin
      prev = m_cnt;
      tick();
      if (pwm !== (prev < duty)) errs++;
      if (pwm === 1'b1) highs++;
    end
    checks++;
    if (errs != 0 || highs != exp_hi) begin
      fails++;
      $display("FAIL %s: pwm_cycle_errs=%0d highs=%0d expected_highs=%0d", nm, errs, highs, exp_hi);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; pid_out = '0; pid_done = 1'b0;
    base_duty = 16'd50; min_duty = 16'd5; max_duty = 16'd95; period = 16'd100;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (pwm !== 1'b0 || duty_active !== 16'd0 || sat_hi !== 1'b0 || sat_lo !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: pwm=%b duty=%0d hi=%b lo=%b ovr=%b expected all 0",
               pwm, duty_active, sat_hi, sat_lo, overrun);
    end
    release_reset();
  endtask

  task automatic test_basic();
    go_to_cnt(10);
    pulse(32'h0000_0A00);
    checks++;
    if (duty_active !== 16'd0 || sat_hi !== 1'b0 || sat_lo !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL basic_capture: duty=%0d hi=%b lo=%b ovr=%b expected 0 0 0 0", duty_active, sat_hi, sat_lo, overrun);
    end
    go_to_cnt(99);
    checks++;
    if (duty_active !== 16'd0 || pwm !== 1'b0) begin
      fails++;
      $display("FAIL basic_prewrap: duty=%0d pwm=%b expected 0 0", duty_active, pwm);
    end
    tick();
    checks++;
    if (duty_active !== 16'd60) begin
      fails++;
      $display("FAIL basic_load: duty=%0d expected 60", duty_active);
    end
    run_period(100, 60, 60, "basic_pwm60");
  endtask

  task automatic test_saturation();
    go_to_cnt(5);
    pulse(32'hFFFF_9C00);
    checks++;
    if (sat_lo !== 1'b1 || sat_hi !== 1'b0) begin
      fails++;
      $display("FAIL sat_lo_flag: hi=%b lo=%b expected 0 1", sat_hi, sat_lo);
    end
    go_to_cnt(99); tick();
    checks++;
    if (duty_active !== 16'd5) begin
      fails++;
      $display("FAIL sat_lo_duty: duty=%0d expected 5", duty_active);
    end
    go_to_cnt(5);
    pulse(32'h0001_0000);
    checks++;
    if (sat_hi !== 1'b1 || sat_lo !== 1'b0) begin
      fails++;
      $display("FAIL sat_hi_flag: hi=%b lo=%b expected 1 0", sat_hi, sat_lo);
    end
    go_to_cnt(99); tick();
    checks++;
    if (duty_active !== 16'd95) begin
      fails++;
      $display("FAIL sat_hi_duty: duty=%0d expected 95", duty_active);
    end
  endtask

  task automatic test_overrun();
    go_to_cnt(10);
    pulse(32'h0000_0A00);
    checks++;
    if (overrun !== 1'b0 || sat_hi !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first: ovr=%b hi=%b expected 0 0", overrun, sat_hi);
    end
    go_to_cnt(20);
    pulse(32'h0000_1400);
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_pulse: ovr=%b expected 1", overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_width: ovr=%b expected 0", overrun);
    end
    go_to_cnt(99); tick();
    checks++;
    if (duty_active !== 16'd70) begin
      fails++;
      $display("FAIL ovr_duty: duty=%0d expected 70", duty_active);
    end
  endtask

  task automatic test_back_to_back();
    go_to_cnt(30);
    pulse(32'h0000_1E00);
    go_to_cnt(99);
    pulse(32'h0000_2800);
    checks++;
    if (duty_active !== 16'd80 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL wrap_coincide: duty=%0d ovr=%b expected 80 0", duty_active, overrun);
    end
    go_to_cnt(99); tick();
    checks++;
    if (duty_active !== 16'd90) begin
      fails++;
      $display("FAIL wrap_next: duty=%0d expected 90", duty_active);
    end
  endtask

  task automatic test_period_en();
    int errs;
    go_to_cnt(30);
    period = 16'd50;
    pulse(32'hFFFF_E200);
    go_to_cnt(99);
    checks++;
    if (duty_active !== 16'd90) begin
      fails++;
      $display("FAIL period_hold: duty=%0d expected 90", duty_active);
    end
    tick();
    checks++;
    if (duty_active !== 16'd20) begin
      fails++;
      $display("FAIL period_wrap100: duty=%0d expected 20", duty_active);
    end
    go_to_cnt(5);
    pulse(32'hFFFF_EC00);
    go_to_cnt(49); tick();
    checks++;
    if (duty_active !== 16'd30) begin
      fails++;
      $display("FAIL period_wrap50: duty=%0d expected 30", duty_active);
    end
    run_period(50, 30, 30, "period50_pwm30");
    go_to_cnt(10);
    en = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pwm !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin
      fails++;
      $display("FAIL en_low_pwm: high_cycles=%0d expected 0", errs);
    end
    en = 1'b1;
    go_to_cnt(30);
    checks++;
    if (pwm !== 1'b1) begin
      fails++;
      $display("FAIL en_freeze_a: pwm=%b expected 1", pwm);
    end
    tick();
    checks++;
    if (pwm !== 1'b0) begin
      fails++;
      $display("FAIL en_freeze_b: pwm=%b expected 0", pwm);
    end
  endtask

  task automatic test_reset_mid();
    go_to_cnt(5);
    pulse(32'hFFFF_FB00);
    go_to_cnt(49); tick();
    checks++;
    if (duty_active !== 16'd45) begin
      fails++;
      $display("FAIL rst_setup: duty=%0d expected 45", duty_active);
    end
    go_to_cnt(20);
    pulse(32'h0000_0A00);
    go_to_cnt(40);
    checks++;
    if (pwm !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_pwm: pwm=%b expected 1", pwm);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0 || duty_active !== 16'd0) begin
      fails++;
      $display("FAIL rst_async: pwm=%b duty=%0d expected 0 0", pwm, duty_active);
    end
    repeat (2) @(posedge clk);
    release_reset();
    go_to_cnt(49); tick(); tick();
    checks++;
    if (duty_active !== 16'd0 || pwm !== 1'b0) begin
      fails++;
      $display("FAIL rst_discard: duty=%0d pwm=%b expected 0 0", duty_active, pwm);
    end
    pulse(32'h0000_0000);
    go_to_cnt(49);
    checks++;
    if (pwm !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle_pwm: pwm=%b expected 0", pwm);
    end
    tick();
    checks++;
    if (duty_active !== 16'd50) begin
      fails++;
      $display("FAIL full_duty_load: duty=%0d expected 50", duty_active);
    end
    run_period(50, 50, 50, "const_high");
    min_duty = 16'd0; base_duty = 16'd0;
    pulse(32'h0000_0000);
    checks++;
    if (sat_lo !== 1'b0 || sat_hi !== 1'b0) begin
      fails++;
      $display("FAIL zero_flags: hi=%b lo=%b expected 0 0", sat_hi, sat_lo);
    end
    go_to_cnt(49); tick();
    checks++;
    if (duty_active !== 16'd0) begin
      fails++;
      $display("FAIL zero_duty: duty=%0d expected 0", duty_active);
    end
    run_period(50, 0, 0, "const_low");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_period_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
